// File: rtl/tempsens_pkg.sv
// Shared types for the temperature-sensor UART link (host and sensor side).
// States, error-cause codes and the default measure command byte.
package tempsens_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND_CMD,
      WAIT_LO,
      WAIT_HI,
      DONE,
      ERR
   } ts_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_FRAME   = 2'b10;

   localparam logic [7:0] CMD_MEASURE_DEF = 8'h01;

endpackage

// File: rtl/uart_8n1_phy.sv
// 8N1 UART bit engine: tx shifter with start/busy handshake, and a
// double-synchronized rx sampler with false-start and framing checks.
module uart_8n1_phy #(
   parameter int BIT_CYC = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       tx_busy,
   output logic       tx,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_ready,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   localparam int CW = $clog2(BIT_CYC);
   localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);

   logic [9:0]    tx_sh;
   logic [3:0]    tx_bit;
   logic [CW-1:0] tx_cnt;

   logic          rx_m;
   logic          rx_s;
   logic          rx_d;
   logic          rx_on;
   logic [3:0]    rx_idx;
   logic [CW-1:0] rx_cnt;
   logic [7:0]    rx_sh;

   // tx: load {stop, data, start} and shift LSB first every BIT_CYC clocks
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_busy <= 1'b0;
         tx_sh   <= '1;
         tx_bit  <= '0;
         tx_cnt  <= '0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy <= 1'b1;
            tx_sh   <= {1'b1, tx_byte, 1'b0};
            tx_bit  <= '0;
            tx_cnt  <= '0;
         end
      end else if (tx_cnt == CYC_LAST) begin
         tx_cnt <= '0;
         if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0;
         end else begin
            tx_bit <= tx_bit + 4'd1;
            tx_sh  <= {1'b1, tx_sh[9:1]};
         end
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
      end
   end

   assign tx = tx_busy ? tx_sh[0] : 1'b1;

   // rx: two-flop synchronizer plus one history flop for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   // rx: hunt for a falling edge, confirm at mid start bit, then sample
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_on        <= 1'b0;
         rx_idx       <= '0;
         rx_cnt       <= '0;
         rx_sh        <= '0;
         rx_byte      <= '0;
         rx_ready     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_ready     <= 1'b0;
         rx_frame_err <= 1'b0;
         if (!rx_on) begin
            if (rx_d && !rx_s) begin
               rx_on  <= 1'b1;
               rx_idx <= '0;
               rx_cnt <= HALF_LAST;
            end
         end else if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
         end else begin
            rx_cnt <= CYC_LAST;
            unique case (1'b1)
               (rx_idx == 4'd0): begin
                  if (rx_s) begin
                     rx_on <= 1'b0;
                  end else begin
                     rx_idx <= 4'd1;
                  end
               end
               (rx_idx == 4'd9): begin
                  rx_on <= 1'b0;
                  if (rx_s) begin
                     rx_byte  <= rx_sh;
                     rx_ready <= 1'b1;
                  end else begin
                     rx_frame_err <= 1'b1;
                  end
               end
               default: begin
                  rx_sh  <= {rx_s, rx_sh[7:1]};
                  rx_idx <= rx_idx + 4'd1;
               end
            endcase
         end
      end
   end

   assign rx_busy = rx_on;

endmodule

// File: rtl/tempsens_reader.sv
// Host-side reader: sends the measure command, collects lo/hi reply bytes.
// Build option TSREAD_RETRY_EN re-sends the command after a failed attempt.
module tempsens_reader
   import tempsens_pkg::*;
#(
   parameter int         CLK_FREQ    = 10000,
   parameter int         BAUD        = 1000,
   parameter logic [7:0] CMD_MEASURE = CMD_MEASURE_DEF,
   parameter int         TIMEOUT     = 2000,
   parameter int         MAX_RETRY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rx,
   output logic        tx,
   output logic [15:0] reading,
   output logic        valid,
   output logic        busy,
   output logic        error,
   output logic [1:0]  err_cause
);

   localparam int BIT_CYC = CLK_FREQ / BAUD;
   localparam int TW      = $clog2(TIMEOUT + 1);
   localparam int RW      = $clog2(MAX_RETRY + 2);

   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);

`ifdef TSREAD_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   ts_state_t     state_q;
   ts_state_t     state_d;
   logic [TW-1:0] tmo_q;
   logic [TW-1:0] tmo_d;
   logic [7:0]    lo_q;
   logic [7:0]    lo_d;
   logic [15:0]   reading_q;
   logic [15:0]   reading_d;
   logic [1:0]    cause_q;
   logic [1:0]    cause_d;
   logic [RW-1:0] retry_q;
   logic [RW-1:0] retry_d;

   logic          tx_start;
   logic          tx_busy;
   logic [7:0]    rx_byte;
   logic          rx_ready;
   logic          rx_frame_err;
   logic          rx_busy;
   logic          fail;
   logic [1:0]    fail_cause;
   logic          retry_left;

   uart_8n1_phy #(
      .BIT_CYC(BIT_CYC)
   ) u_phy (
      .clk         (clk),
      .reset       (reset),
      .tx_start    (tx_start),
      .tx_byte     (CMD_MEASURE),
      .tx_busy     (tx_busy),
      .tx          (tx),
      .rx          (rx),
      .rx_byte     (rx_byte),
      .rx_ready    (rx_ready),
      .rx_frame_err(rx_frame_err),
      .rx_busy     (rx_busy)
   );

   assign retry_left = RETRY_EN && (retry_q != RW'(MAX_RETRY));

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         tmo_q     <= '0;
         lo_q      <= '0;
         reading_q <= '0;
         cause_q   <= ERR_NONE;
         retry_q   <= '0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         lo_q      <= lo_d;
         reading_q <= reading_d;
         cause_q   <= cause_d;
         retry_q   <= retry_d;
      end
   end

   // next state: command, reply collection with per-byte timeout, failures
   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      lo_d       = lo_q;
      reading_d  = reading_q;
      cause_d    = cause_q;
      retry_d    = retry_q;
      tx_start   = 1'b0;
      fail       = 1'b0;
      fail_cause = ERR_NONE;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SEND_CMD;
               tx_start = 1'b1;
               cause_d  = ERR_NONE;
               retry_d  = '0;
               lo_d     = '0;
            end
         end
         SEND_CMD: begin
            if (!tx_busy) begin
               state_d = WAIT_LO;
               tmo_d   = TMO_LOAD;
            end
         end
         WAIT_LO, WAIT_HI: begin
            if (rx_frame_err) begin
               fail       = 1'b1;
               fail_cause = ERR_FRAME;
            end else if (rx_ready) begin
               if (state_q == WAIT_LO) begin
                  lo_d    = rx_byte;
                  tmo_d   = TMO_LOAD;
                  state_d = WAIT_HI;
               end else begin
                  reading_d = {rx_byte, lo_q};
                  state_d   = DONE;
               end
            end else if (!rx_busy) begin
               tmo_d = tmo_q - 1'b1;
               if (tmo_q == TMO_ONE) begin
                  fail       = 1'b1;
                  fail_cause = ERR_TIMEOUT;
               end
            end
            if (fail) begin
               cause_d = fail_cause;
               if (retry_left) begin
                  retry_d  = retry_q + 1'b1;
                  state_d  = SEND_CMD;
                  tx_start = 1'b1;
                  lo_d     = '0;
               end else begin
                  state_d = ERR;
               end
            end
         end
         DONE, ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign valid     = (state_q == DONE);
   assign error     = (state_q == ERR);
   assign busy      = (state_q == SEND_CMD) ||
                      (state_q == WAIT_LO)  ||
                      (state_q == WAIT_HI);
   assign reading   = reading_q;
   assign err_cause = cause_q;

endmodule

// File: tb/tb_tempsens_reader.sv
// Bench for tempsens_reader: a sensor model replies over rx, a tx decoder
// and pulse monitors feed a transaction-level reference model.
`timescale 1ns/1ps
module tb_tempsens_reader;

   localparam int         BIT_CYC   = 10;
   localparam int         TIMEOUT   = 2000;
   localparam int         MAX_RETRY = 2;
   localparam logic [7:0] CMD       = 8'h01;
   localparam int         CMD_CYC   = 10 * BIT_CYC;
`ifdef TSREAD_RETRY_EN
   localparam int         ATTEMPTS  = MAX_RETRY + 1;
`else
   localparam int         ATTEMPTS  = 1;
`endif

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        rx    = 1'b1;
   logic        tx;
   logic [15:0] reading;
   logic        valid;
   logic        busy;
   logic        error;
   logic [1:0]  err_cause;

   int          n_chk = 0;
   int          n_err = 0;
   int          valid_cnt = 0;
   int          err_cnt = 0;
   logic        busy_at_valid = 1'b1;
   logic [15:0] read_at_valid = '0;
   logic [15:0] model_reading = '0;
   logic [7:0]  cmd_q[$];

   always #5 clk = ~clk;

   tempsens_reader #(
      .CLK_FREQ   (10000),
      .BAUD       (1000),
      .CMD_MEASURE(CMD),
      .TIMEOUT    (TIMEOUT),
      .MAX_RETRY  (MAX_RETRY)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .rx       (rx),
      .tx       (tx),
      .reading  (reading),
      .valid    (valid),
      .busy     (busy),
      .error    (error),
      .err_cause(err_cause)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // count output pulses away from the active edge
   always @(negedge clk) begin
      if (valid) begin
         valid_cnt     <= valid_cnt + 1;
         busy_at_valid <= busy;
         read_at_valid <= reading;
      end
      if (error) err_cnt <= err_cnt + 1;
   end

   // behavioural UART receiver on the command line
   initial begin : cmd_mon
      logic [7:0] b;
      b = '0;
      forever begin
         @(negedge tx);
         repeat (BIT_CYC / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT_CYC) @(negedge clk);
            b[i] = tx;
         end
         repeat (BIT_CYC) @(negedge clk);
         cmd_q.push_back(b);
      end
   end

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(BIT_CYC);
      end
      rx = stop;
      tick(BIT_CYC);
      rx = 1'b1;
   endtask

   task automatic wait_evt(input int base, input int budget,
                           output int cycles);
      cycles = 0;
      while (valid_cnt + err_cnt == base && cycles < budget) begin
         tick(1);
         cycles++;
      end
      check("evt_seen", (valid_cnt + err_cnt) != base, 1);
   endtask

   task automatic run_txn(input logic [7:0] lo, input logic [7:0] hi,
                          input int gap1, input int gap2,
                          input bit poke, input bit show_bits);
      int v0;
      int e0;
      int c0;
      int lat;
      logic [9:0] frame;
      v0 = valid_cnt;
      e0 = err_cnt;
      c0 = cmd_q.size();
      frame = {1'b1, CMD, 1'b0};
      do_start();
      if (show_bits) begin
         check("busy_rise", busy, 1);
         tick(BIT_CYC / 2);
         for (int k = 0; k < 10; k++) begin
            check($sformatf("cmd_bit%0d", k), tx, frame[k]);
            if (k < 9) tick(BIT_CYC);
         end
         tick(BIT_CYC);
      end else begin
         tick(CMD_CYC + BIT_CYC / 2);
      end
      tick(gap1);
      send_byte(lo, 1'b1);
      if (poke) do_start();
      tick(gap2);
      send_byte(hi, 1'b1);
      wait_evt(v0 + e0, 200, lat);
      model_reading = {hi, lo};
      tick(2);
      check("valid_pulses", valid_cnt - v0, 1);
      check("err_pulses", err_cnt - e0, 0);
      check("reading", read_at_valid, model_reading);
      check("busy_at_valid", busy_at_valid, 0);
      check("cmd_count", cmd_q.size() - c0, 1);
      if (cmd_q.size() > 0) check("cmd_byte", cmd_q[$], CMD);
   endtask

   initial begin : main
      int lat;
      int e0;
      int v0;
      int c0;
      int nom;
      logic [7:0] lo;
      logic [7:0] hi;

      tick(3);
      check("rst_tx", tx, 1);
      check("rst_reading", reading, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);
      check("rst_cause", err_cause, 0);
      reset = 1'b0;
      tick(2);

      run_txn(8'h34, 8'h12, 0, 0, 1'b0, 1'b1);

      for (int i = 0; i < 4; i++) begin
         lo = 8'($urandom);
         hi = 8'($urandom);
         run_txn(lo, hi, $urandom_range(0, 40), $urandom_range(0, 40),
                 (i == 0) || ($urandom_range(0, 1) == 1), 1'b0);
         tick($urandom_range(1, 20));
      end

      // no reply at all
      e0 = err_cnt;
      v0 = valid_cnt;
      c0 = cmd_q.size();
      do_start();
      wait_evt(v0 + e0, ATTEMPTS * (CMD_CYC + TIMEOUT) + 200, lat);
      nom = ATTEMPTS * (CMD_CYC + TIMEOUT);
      check("tmo_latency", (lat >= nom) && (lat <= nom + 4 * ATTEMPTS), 1);
      tick(2);
      check("tmo_error", err_cnt - e0, 1);
      check("tmo_cause", err_cause, 2'b01);
      check("tmo_reading", reading, model_reading);
      check("tmo_no_valid", valid_cnt - v0, 0);
      check("tmo_cmds", cmd_q.size() - c0, ATTEMPTS);
      tick(5);

      // lo byte with a bad stop bit
      e0 = err_cnt;
      v0 = valid_cnt;
      do_start();
      tick(CMD_CYC + BIT_CYC / 2);
      send_byte(8'h5A, 1'b0);
      wait_evt(v0 + e0, ATTEMPTS * (CMD_CYC + TIMEOUT) + 200, lat);
      tick(2);
      check("frm_error", err_cnt - e0, 1);
      check("frm_cause", err_cause, (ATTEMPTS > 1) ? 2'b01 : 2'b10);
      check("frm_reading", reading, model_reading);
      check("frm_no_valid", valid_cnt - v0, 0);
      tick(5);

      // short low glitch while waiting for lo, then a good reply
      e0 = err_cnt;
      v0 = valid_cnt;
      do_start();
      tick(CMD_CYC + BIT_CYC / 2);
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(30);
      check("glitch_busy", busy, 1);
      check("glitch_no_err", err_cnt - e0, 0);
      send_byte(8'hC3, 1'b1);
      send_byte(8'h7E, 1'b1);
      wait_evt(v0 + e0, 200, lat);
      model_reading = 16'h7EC3;
      tick(2);
      check("glitch_reading", reading, model_reading);
      check("glitch_err", err_cnt - e0, 0);
      check("glitch_cause", err_cause, 2'b00);
      tick(5);

      // reset while waiting for hi
      v0 = valid_cnt;
      e0 = err_cnt;
      do_start();
      tick(CMD_CYC + BIT_CYC / 2);
      send_byte(8'h99, 1'b1);
      tick(5);
      reset = 1'b1;
      tick(1);
      model_reading = '0;
      check("mid_rst_tx", tx, 1);
      check("mid_rst_reading", reading, model_reading);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", valid, 0);
      check("mid_rst_error", error, 0);
      check("mid_rst_cause", err_cause, 0);
      reset = 1'b0;
      tick(3);
      check("mid_rst_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);

      run_txn(8'hEF, 8'hBE, 3, 3, 1'b1, 1'b0);
      check("beef", reading, 16'hBEEF);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
